// File: rtl/uart_pkg.sv
// uart_pkg: shared UART state encoding, limits and clamps for clk_div / bits_per_word
package uart_pkg;
  localparam int UART_MAX_BITS = 16;
  localparam int UART_MIN_DIV = 4;
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} uart_state_t;
  function automatic logic [31:0] clamp_div(input logic [31:0] d);
    return d < 32'(UART_MIN_DIV) ? 32'(UART_MIN_DIV) : d;
  endfunction
  function automatic logic [4:0] clamp_bits(input logic [4:0] b);
    return (b == 5'd0 || b > 5'(UART_MAX_BITS)) ? 5'(UART_MAX_BITS) : b;
  endfunction
endpackage

// File: rtl/uart_rx_sync.sv
// uart_rx_sync: two-flop rx synchronizer with falling-edge detect (clk, rst, rx in; rx_s, fall out)
module uart_rx_sync (
  input  logic clk,
  input  logic rst,
  input  logic rx,
  output logic rx_s,
  output logic fall
);
  logic s1, s2, s3;
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b1;
      s2 <= 1'b1;
      s3 <= 1'b1;
    end else begin
      s1 <= rx;
      s2 <= s1;
      s3 <= s2;
    end
  end
  assign rx_s = s2;
  assign fall = s3 & ~s2;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: UART receiver (clk, rst, rx, clk_div, bits_per_word, rd_en in; data_out, new_data, data_valid, busy, frame_err, overrun out)
module uart_rx
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int DIV_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  input  logic [DIV_WIDTH-1:0]  clk_div,
  input  logic [4:0]            bits_per_word,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] data_out,
  output logic                  new_data,
  output logic                  data_valid,
  output logic                  busy,
  output logic                  frame_err,
  output logic                  overrun
);
  uart_state_t state, state_nxt;
  logic rx_s, fall, expire, done;
  logic [DIV_WIDTH-1:0] cnt, div, div_eff;
  logic [4:0] n, k, sh_amt;
  logic [DATA_WIDTH-1:0] sh;
  uart_rx_sync u_sync (.clk(clk), .rst(rst), .rx(rx), .rx_s(rx_s), .fall(fall));
  assign div_eff = DIV_WIDTH'(clamp_div(32'(clk_div)));
  // bits arrive LSB first into the top of sh, so shift down by the unused width
  assign sh_amt = 5'(DATA_WIDTH) - n;
  always_comb begin
    expire = cnt == DIV_WIDTH'(1);
    done = state == STOP && expire;
    busy = state != IDLE;
    state_nxt = state == IDLE ? (fall ? START : IDLE) :
                !expire ? state :
                state == START ? (rx_s ? IDLE : DATA) :
                state == DATA ? (k == n - 5'd1 ? STOP : DATA) : IDLE;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= '0;
      div <= '0;
      n <= '0;
      k <= '0;
      sh <= '0;
      data_out <= '0;
      new_data <= 1'b0;
      frame_err <= 1'b0;
      data_valid <= 1'b0;
      overrun <= 1'b0;
    end else begin
      state <= state_nxt;
      new_data <= done;
      frame_err <= done & ~rx_s;
      if (state == IDLE && fall) begin
        div <= div_eff;
        n <= clamp_bits(bits_per_word);
        cnt <= div_eff >> 1;
        k <= '0;
      end else if (state != IDLE) cnt <= expire ? div : cnt - 1'b1;
      if (state == DATA && expire) begin
        sh <= {rx_s, sh[DATA_WIDTH-1:1]};
        k <= k + 5'd1;
      end
      if (done) data_out <= sh >> sh_amt;
      data_valid <= done | (data_valid & ~rd_en);
      if (done && data_valid && !rd_en) overrun <= 1'b1;
    end
  end
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: randomized scoreboard bench for uart_rx against a frame-level reference model
module tb_uart_rx;
  logic clk = 1'b0, rst = 1'b1, rx = 1'b1, rd_en = 1'b0;
  logic [15:0] clk_div = 16'd16;
  logic [4:0] bits_per_word = 5'd8;
  logic [15:0] data_out;
  logic new_data, data_valid, busy, frame_err, overrun;
  int checks = 0, errors = 0, cyc = 0, fall_cyc = 0;
  logic exp_valid = 1'b0, exp_ovr = 1'b0;
  logic [15:0] last_word = 16'h0;
  typedef struct {
    logic [15:0] data;
    logic ferr;
    logic valid;
    logic ovr;
    int lat;
  } exp_t;
  exp_t q[$];
  exp_t e;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  uart_rx dut (
    .clk(clk), .rst(rst), .rx(rx), .clk_div(clk_div), .bits_per_word(bits_per_word),
    .rd_en(rd_en), .data_out(data_out), .new_data(new_data), .data_valid(data_valid),
    .busy(busy), .frame_err(frame_err), .overrun(overrun)
  );
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  always @(negedge clk) begin
    if (!rst && new_data) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_new_data: got data_out %0h with no frame outstanding", data_out);
      end else begin
        e = q.pop_front();
        chk("data_out", 32'(data_out), 32'(e.data));
        chk("frame_err", 32'(frame_err), 32'(e.ferr));
        chk("data_valid", 32'(data_valid), 32'(e.valid));
        chk("overrun", 32'(overrun), 32'(e.ovr));
        chk("busy_at_load", 32'(busy), 32'd0);
        chk("latency", 32'(cyc - fall_cyc), 32'(e.lat));
      end
    end else if (!rst && frame_err) chk("frame_err_alone", 32'(frame_err), 32'd0);
  end
  task automatic check_reset_vals(input string tag);
    chk({tag, "_data_out"}, 32'(data_out), 32'd0);
    chk({tag, "_flags"}, {26'd0, new_data, data_valid, busy, frame_err, overrun}, 32'd0);
  endtask
  task automatic rst_pulse();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
    exp_valid = 1'b0;
    exp_ovr = 1'b0;
    last_word = '0;
  endtask
  task automatic read();
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    exp_valid = 1'b0;
    chk("valid_after_read", 32'(data_valid), 32'd0);
  endtask
  task automatic send(input logic [15:0] w, input logic [15:0] dr, input logic [4:0] nr,
                      input logic stop, input logic rd_load, input int abort_bit);
    int d, n, s;
    logic [31:0] m;
    d = dr < 16'd4 ? 4 : int'(dr);
    n = (nr == 5'd0 || nr > 5'd16) ? 16 : int'(nr);
    s = 2 + d / 2 + (n + 1) * d;
    m = (32'd1 << n) - 32'd1;
    clk_div = dr;
    bits_per_word = nr;
    @(negedge clk);
    rx = 1'b0;
    fall_cyc = cyc;
    tick(2);
    chk("busy_before_detect", 32'(busy), 32'd0);
    tick(1);
    chk("busy_after_detect", 32'(busy), 32'd1);
    clk_div = 16'($urandom);
    bits_per_word = 5'($urandom);
    tick(d - 3);
    for (int i = 0; i < n; i++) begin
      if (i == abort_bit) begin
        tick(d / 2);
        rst = 1'b1;
        rx = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_valid = 1'b0;
        exp_ovr = 1'b0;
        last_word = '0;
        check_reset_vals("abort");
        tick(2 * d);
        return;
      end
      rx = w[i];
      tick(d);
    end
    e.data = w & m[15:0];
    e.ferr = ~stop;
    e.valid = 1'b1;
    e.ovr = exp_ovr | (exp_valid & ~rd_load);
    e.lat = s + 1;
    q.push_back(e);
    exp_valid = 1'b1;
    exp_ovr = e.ovr;
    last_word = e.data;
    if (rd_load) fork
      begin
        repeat (2 + d / 2) @(negedge clk);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
      end
    join_none
    rx = stop;
    tick(d);
    rx = 1'b1;
    tick(d / 2 + 2 + int'($urandom_range(0, 3)));
  endtask
  initial begin
    tick(3);
    check_reset_vals("reset");
    rst = 1'b0;
    tick(2);
    send(16'h0050, 16, 8, 1'b1, 1'b0, -1);
    chk("valid_held", 32'(data_valid), 32'd1);
    read();
    clk_div = 16;
    bits_per_word = 8;
    @(negedge clk);
    rx = 1'b0;
    tick(4);
    rx = 1'b1;
    tick(6);
    chk("glitch_busy_hold", 32'(busy), 32'd1);
    tick(1);
    chk("glitch_busy_drop", 32'(busy), 32'd0);
    tick(20);
    chk("glitch_data_kept", 32'(data_out), 32'(last_word));
    send(16'h00A5, 16, 8, 1'b0, 1'b0, -1);
    read();
    send(16'h0012, 16, 8, 1'b1, 1'b0, -1);
    send(16'h0034, 16, 8, 1'b1, 1'b0, -1);
    chk("overrun_sticky", 32'(overrun), 32'd1);
    rst_pulse();
    send(16'h0012, 16, 8, 1'b1, 1'b0, -1);
    send(16'h0034, 16, 8, 1'b1, 1'b1, -1);
    chk("rd_at_load_valid", 32'(data_valid), 32'd1);
    chk("rd_at_load_no_ovr", 32'(overrun), 32'd0);
    read();
    send(16'hBEEF, 2, 0, 1'b1, 1'b0, -1);
    read();
    send(16'h001F, 16, 5, 1'b1, 1'b0, -1);
    read();
    send(16'h005A, 16, 8, 1'b1, 1'b0, 3);
    send(16'h005A, 16, 8, 1'b1, 1'b0, -1);
    read();
    clk_div = 8;
    bits_per_word = 8;
    @(negedge clk);
    rx = 1'b0;
    fall_cyc = cyc;
    e.data = 16'h0;
    e.ferr = 1'b1;
    e.valid = 1'b1;
    e.ovr = exp_ovr | exp_valid;
    e.lat = 3 + 4 + 9 * 8;
    q.push_back(e);
    exp_valid = 1'b1;
    exp_ovr = e.ovr;
    tick(200);
    chk("held_low_idle", 32'(busy), 32'd0);
    rx = 1'b1;
    tick(20);
    read();
    for (int i = 0; i < 30; i++) begin
      send(16'($urandom), 16'($urandom_range(0, 20)), 5'($urandom_range(0, 20)),
           $urandom_range(0, 7) != 0, $urandom_range(0, 3) == 0, -1);
      if ($urandom_range(0, 1) == 1) read();
    end
    tick(10);
    chk("scoreboard_drained", 32'(q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
